ps2_key_ctrl: RTL
=================

// Module: ps2_key_ctrl
// PURPOSE
//  Drains the ps2_if receive FIFO and turns PS/2 Set-2 byte streams into key events.
//  Handles E0, F0, E0-F0 and E1 (Pause) prefixes; replaces the ad-hoc pop/decode logic in the top level.
//  Emits a one-cycle key_valid pulse with code, extended and break flags to TETRIS_GAME.
//  Runs in the 25 MHz clk domain. Sits between ps2_if and the game logic.
// PARAMETERS
//  PREFIX_TIMEOUT  50000  clk cycles allowed between prefix and next byte (2 ms); 0 = no timeout
//  TO_W            16     width of timeout counter; must hold PREFIX_TIMEOUT
// PORTS
//  clk         in   1  25 MHz system clock
//  rst         in   1  asynchronous, active-high reset
//  fifo_empty  in   1  ps2_if status[0]; 1 = FIFO empty
//  fifo_data   in   8  ps2_if data[7:0]; first-word-fall-through, valid while !fifo_empty
//  fifo_rd     out  1  pop strobe to ps2_if, one cycle wide
//  key_code    out  8  scan code of last event (low byte, prefixes stripped)
//  key_ext     out  1  event had E0 prefix
//  key_brk     out  1  1 = break (release), 0 = make (press)
//  key_valid   out  1  one-cycle pulse, key_* valid in that cycle
//  kbd_err     out  1  sticky, set on keyboard error byte 0x00/0xFF or prefix timeout
// BEHAVIOUR
//  Reset: fifo_rd=0, key_code=8'h00, key_ext=0, key_brk=0, key_valid=0, kbd_err=0.
//   Reset also clears decode state, timeout counter and held-key register. Reset mid-sequence discards it.
//  Pop engine (POP_IDLE, POP_GAP):
//   - POP_IDLE & !fifo_empty: assert fifo_rd, sample fifo_data into decoder in the same cycle, go to POP_GAP.
//   - POP_GAP: fifo_rd=0 for 1 cycle (covers empty-flag update), then return to POP_IDLE.
//   - Max pop rate: one byte per 2 cycles.
//  Decoder states: D_BASE, D_EXT, D_BRK, D_EXTBRK, D_SKIP.
//   - D_BASE: E0->D_EXT; F0->D_BRK; E1->D_SKIP with skip_cnt=7.
//     AA/FA/EE/FE: dropped silently. 00/FF: dropped, kbd_err=1.
//     Any other byte: make event, ext=0.
//   - D_EXT: F0->D_EXTBRK; 12 or 59 (fake shift)->D_BASE, no event; other byte: make event, ext=1, ->D_BASE.
//   - D_BRK: any byte: break event, ext=0, ->D_BASE.
//   - D_EXTBRK: 12/59->D_BASE, no event; other byte: break event, ext=1, ->D_BASE.
//   - D_SKIP: each popped byte decrements skip_cnt; at 0 ->D_BASE. No event, no timeout.
//  Timing: event byte popped in cycle N -> key_* registered and key_valid=1 in cycle N+1.
//   key_* hold their value until the next event.
//  Timeout: counter clears on every pop. In D_EXT, D_BRK or D_EXTBRK it counts each idle cycle.
//   Reaching PREFIX_TIMEOUT: ->D_BASE, kbd_err=1, no event.
//   A byte arriving in the same cycle as expiry is decoded normally; the pop wins over the timeout.
//  key_valid is never high on two consecutive cycles, because of POP_GAP.
// CONFIGURATION
//  PS2_TYPEMATIC_FILTER_EN defined:
//   - Holds one {valid, ext, code} held-key register.
//   - A make equal to the held key is suppressed (auto-repeat). Any other make is emitted and replaces the held key.
//   - A break equal to the held key is emitted and clears the register. Other breaks are emitted, register unchanged.
//  PS2_TYPEMATIC_FILTER_EN undefined: every decoded make/break is emitted; no held-key register.
// STRUCTURE
//  ps2_key_defs.vh (shared include): localparams PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_PAUSE=8'hE1,
//   PS2_BAT=8'hAA, PS2_ACK=8'hFA, PS2_ECHO=8'hEE, PS2_RESEND=8'hFE, PS2_ERR0=8'h00, PS2_ERR1=8'hFF,
//   fake-shift codes 8'h12/8'h59, decoder state encodings. Also used by TETRIS_GAME key mapping.
//  No sub-module: pop engine, decoder FSM and timeout counter live in this module.
// TESTING
//  1 FIFO bytes 1D -> fifo_rd one pulse; one cycle later key_valid=1, code=1D, ext=0, brk=0.
//  2 Bytes E0 75 then E0 F0 75 -> make ext=1 code=75, then break ext=1 code=75; exactly 2 pulses.
//  3 Pause E1 14 77 E1 F0 14 F0 77 -> 8 pops, zero key_valid; then 1C -> make 1C.
//  4 E0, then 50000 idle cycles -> kbd_err=1, no event; next 6B -> make ext=0 code=6B.
//  5 FIFO holding 4 bytes -> fifo_rd pulses spaced exactly 2 cycles; rst asserted after F0 -> all outputs 0; next byte 29 decodes as make.
//  6 FILTER_EN: 1D 1D 1D F0 1D -> one make 1D, one break 1D; undefined: 3 makes + 1 break.

Source files
------------

// File: rtl/ps2_key_ctrl_pkg.sv
// Shared PS/2 Set-2 constants and decoder state encodings for ps2_key_ctrl and the game key mapping.
package ps2_key_ctrl_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ERR0   = 8'h00;
  localparam logic [7:0] PS2_ERR1   = 8'hFF;
  localparam logic [7:0] PS2_FSHIFT_L = 8'h12;
  localparam logic [7:0] PS2_FSHIFT_R = 8'h59;

  // The Pause sequence carries seven more bytes after its E1 lead-in.
  localparam logic [2:0] PAUSE_TAIL = 3'd7;

  typedef enum logic [2:0] {
    D_BASE,
    D_EXT,
    D_BRK,
    D_EXTBRK,
    D_SKIP
  } dec_state_t;

  typedef enum logic {
    POP_IDLE,
    POP_GAP
  } pop_state_t;

  function automatic logic is_fake_shift(input logic [7:0] b);
    return (b == PS2_FSHIFT_L) || (b == PS2_FSHIFT_R);
  endfunction

  function automatic logic is_status(input logic [7:0] b);
    return (b == PS2_BAT) || (b == PS2_ACK) || (b == PS2_ECHO) || (b == PS2_RESEND);
  endfunction

  function automatic logic is_error(input logic [7:0] b);
    return (b == PS2_ERR0) || (b == PS2_ERR1);
  endfunction

endpackage

// File: rtl/ps2_key_ctrl.sv
// Drains the ps2_if FIFO and decodes PS/2 Set-2 byte streams into one-cycle key events.
// Optional auto-repeat suppression is enabled with `define PS2_TYPEMATIC_FILTER_EN.
module ps2_key_ctrl
  import ps2_key_ctrl_pkg::*;
#(
  parameter int PREFIX_TIMEOUT = 50000,
  parameter int TO_W           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_brk,
  output logic       key_valid,
  output logic       kbd_err
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(PREFIX_TIMEOUT - 1);

  pop_state_t      pop_state, pop_next;
  dec_state_t      dec_state, dec_next;
  logic [2:0]      skip_cnt, skip_next;
  logic [TO_W-1:0] to_cnt;
  logic            pop;
  logic            in_prefix;
  logic            to_expire;
  logic            ev, ev_ext, ev_brk;
  logic            emit;
  logic            set_err;

  assign pop       = (pop_state == POP_IDLE) && !fifo_empty;
  assign in_prefix = (dec_state == D_EXT) || (dec_state == D_BRK) || (dec_state == D_EXTBRK);
  // A byte popped in the expiry cycle is decoded; the pop wins over the timeout.
  assign to_expire = (PREFIX_TIMEOUT != 0) && in_prefix && !pop && (to_cnt == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pop_state <= POP_IDLE;
      dec_state <= D_BASE;
      skip_cnt  <= 3'd0;
    end else begin
      pop_state <= pop_next;
      dec_state <= dec_next;
      skip_cnt  <= skip_next;
    end
  end

  always_comb begin
    pop_next = pop_state;
    fifo_rd  = 1'b0;
    case (pop_state)
      POP_IDLE: begin
        if (!fifo_empty) begin
          fifo_rd  = 1'b1;
          pop_next = POP_GAP;
        end
      end
      default: pop_next = POP_IDLE;
    endcase
  end

  always_comb begin
    dec_next  = dec_state;
    skip_next = skip_cnt;
    ev        = 1'b0;
    ev_ext    = 1'b0;
    ev_brk    = 1'b0;
    set_err   = 1'b0;
    if (pop) begin
      case (dec_state)
        D_BASE: begin
          if (fifo_data == PS2_EXT) begin
            dec_next = D_EXT;
          end else if (fifo_data == PS2_BRK) begin
            dec_next = D_BRK;
          end else if (fifo_data == PS2_PAUSE) begin
            dec_next  = D_SKIP;
            skip_next = PAUSE_TAIL;
          end else if (is_error(fifo_data)) begin
            set_err = 1'b1;
          end else if (!is_status(fifo_data)) begin
            ev = 1'b1;
          end
        end
        D_EXT: begin
          if (fifo_data == PS2_BRK) begin
            dec_next = D_EXTBRK;
          end else begin
            dec_next = D_BASE;
            ev       = !is_fake_shift(fifo_data);
            ev_ext   = 1'b1;
          end
        end
        D_BRK: begin
          dec_next = D_BASE;
          ev       = 1'b1;
          ev_brk   = 1'b1;
        end
        D_EXTBRK: begin
          dec_next = D_BASE;
          ev       = !is_fake_shift(fifo_data);
          ev_ext   = 1'b1;
          ev_brk   = 1'b1;
        end
        D_SKIP: begin
          skip_next = skip_cnt - 3'd1;
          if (skip_cnt <= 3'd1) begin
            dec_next = D_BASE;
          end
        end
        default: dec_next = D_BASE;
      endcase
    end else if (to_expire) begin
      dec_next = D_BASE;
      set_err  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (pop || !in_prefix || to_expire) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic       held_valid;
  logic       held_ext;
  logic [7:0] held_code;
  logic       held_match;

  assign held_match = held_valid && (held_ext == ev_ext) && (held_code == fifo_data);

  // Repeated makes of the currently held key are auto-repeat and get swallowed.
  always_comb begin
    emit = ev;
    if (ev && !ev_brk && held_match) begin
      emit = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_valid <= 1'b0;
      held_ext   <= 1'b0;
      held_code  <= 8'h00;
    end else if (ev && !ev_brk && !held_match) begin
      held_valid <= 1'b1;
      held_ext   <= ev_ext;
      held_code  <= fifo_data;
    end else if (ev && ev_brk && held_match) begin
      held_valid <= 1'b0;
    end
  end
`else
  assign emit = ev;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_code  <= 8'h00;
      key_ext   <= 1'b0;
      key_brk   <= 1'b0;
      key_valid <= 1'b0;
      kbd_err   <= 1'b0;
    end else begin
      key_valid <= emit;
      if (set_err) begin
        kbd_err <= 1'b1;
      end
      if (emit) begin
        key_code <= fifo_data;
        key_ext  <= ev_ext;
        key_brk  <= ev_brk;
      end
    end
  end

endmodule
